// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Flag bit positions within the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] ALU_ADD = 4'h0;

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way round-robin picker; a held lock restricts the pick to the current owner.
module alu_arb_rr2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       lock_q,
    input  logic       owner,
    output logic [1:0] grant
);

    logic [1:0] mask_s;
    logic [1:0] cand_s;

    // Mask out the non-owner while locked, then pick, favouring the requester not granted last.
    always_comb begin
        mask_s = 2'b11;
        if (lock_q) begin
            mask_s = owner ? 2'b10 : 2'b01;
        end else begin
            mask_s = 2'b11;
        end
        cand_s = valid & mask_s;
        case (cand_s)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin
// arbitration, registered responses and an optional carry-chaining bus lock.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CTRL_W       = 4,
    parameter int FLAG_W       = 4,
    parameter int CARRY_BIT    = 1,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic              r0_cin,
    input  logic              r0_cin_sel,
    input  logic              r0_lock,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [WIDTH-1:0]  r0_result,
    output logic [FLAG_W-1:0] r0_flags,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [CTRL_W-1:0] r1_ctrl,
    input  logic              r1_cin,
    input  logic              r1_cin_sel,
    input  logic              r1_lock,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [WIDTH-1:0]  r1_result,
    output logic [FLAG_W-1:0] r1_flags,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_cin,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              busy,
    output logic              lock_timeout
);

    localparam logic [7:0] TMO = 8'(LOCK_TIMEOUT);

    state_t            state_r, state_s;
    logic              last_grant_r, owner_r, lock_r, carry_r, pulse_r;
    logic [7:0]        tcnt_r;
    logic [WIDTH-1:0]  op_a_r, op_b_r;
    logic [CTRL_W-1:0] op_ctrl_r;
    logic              op_cin_r;
    logic [WIDTH-1:0]  result_r [2];
    logic [FLAG_W-1:0] flags_r [2];
    logic [1:0]        rsp_valid_r;

    logic [1:0]        valid_s, grant_s, ready_s, rsp_ready_s;
    logic              accept_s, acc_id_s, acc_cin_s, acc_lock_s;
    logic              rsp_done_s, count_s, hit_s;
    logic [WIDTH-1:0]  acc_a_s, acc_b_s;
    logic [CTRL_W-1:0] acc_ctrl_s;

    assign valid_s     = {r1_valid, r0_valid};
    assign rsp_ready_s = {r1_rsp_ready, r0_rsp_ready};

    alu_arb_rr2 u_rr2 (
        .valid      (valid_s),
        .last_grant (last_grant_r),
        .lock_q     (lock_r),
        .owner      (owner_r),
        .grant      (grant_s)
    );

    // Handshake qualification, accepted-request mux and lock-timeout conditions.
    always_comb begin
        ready_s = 2'b00;
        if (state_r == IDLE) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
        accept_s = |(valid_s & ready_s);
        acc_id_s = grant_s[1];
        if (acc_id_s) begin
            acc_a_s    = r1_a;
            acc_b_s    = r1_b;
            acc_ctrl_s = r1_ctrl;
            acc_cin_s  = r1_cin_sel ? carry_r : r1_cin;
            acc_lock_s = r1_lock;
        end else begin
            acc_a_s    = r0_a;
            acc_b_s    = r0_b;
            acc_ctrl_s = r0_ctrl;
            acc_cin_s  = r0_cin_sel ? carry_r : r0_cin;
            acc_lock_s = r0_lock;
        end
        rsp_done_s = rsp_valid_r[owner_r] & rsp_ready_s[owner_r];
        // The counter parks at TMO for exactly one cycle: that is the pulse cycle.
        count_s    = (state_r == IDLE) && lock_r && !valid_s[owner_r] && (tcnt_r != TMO);
        hit_s      = (tcnt_r == TMO);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? EXEC : IDLE;
            EXEC:    state_s = RESP;
            RESP:    state_s = rsp_done_s ? IDLE : RESP;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand registers feed the ALU directly and hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r    <= {WIDTH{1'b0}};
            op_b_r    <= {WIDTH{1'b0}};
            op_ctrl_r <= {CTRL_W{1'b0}};
            op_cin_r  <= 1'b0;
        end else if (accept_s) begin
            op_a_r    <= acc_a_s;
            op_b_r    <= acc_b_s;
            op_ctrl_r <= acc_ctrl_s;
            op_cin_r  <= acc_cin_s;
        end
    end

    // Grant history, ownership, lock and lock-timeout tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            lock_r       <= 1'b0;
            tcnt_r       <= 8'd0;
            pulse_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                last_grant_r <= acc_id_s;
                owner_r      <= acc_id_s;
                lock_r       <= acc_lock_s;
                tcnt_r       <= 8'd0;
            end else if (hit_s) begin
                lock_r <= 1'b0;
                tcnt_r <= 8'd0;
            end else if (count_s) begin
                tcnt_r <= tcnt_r + 8'd1;
            end
            pulse_r <= count_s && (tcnt_r == TMO - 8'd1);
        end
    end

    // Response capture into the owner's registers and carry bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r[0] <= {WIDTH{1'b0}};
            result_r[1] <= {WIDTH{1'b0}};
            flags_r[0]  <= {FLAG_W{1'b0}};
            flags_r[1]  <= {FLAG_W{1'b0}};
            rsp_valid_r <= 2'b00;
            carry_r     <= 1'b0;
        end else if (state_r == EXEC) begin
            result_r[owner_r]    <= alu_result;
            flags_r[owner_r]     <= alu_flags;
            rsp_valid_r[owner_r] <= 1'b1;
            carry_r              <= alu_flags[CARRY_BIT];
        end else if ((state_r == RESP) && rsp_done_s) begin
            rsp_valid_r[owner_r] <= 1'b0;
        end
    end

    assign r0_ready     = ready_s[0];
    assign r1_ready     = ready_s[1];
    assign r0_rsp_valid = rsp_valid_r[0];
    assign r1_rsp_valid = rsp_valid_r[1];
    assign r0_result    = result_r[0];
    assign r1_result    = result_r[1];
    assign r0_flags     = flags_r[0];
    assign r1_flags     = flags_r[1];
    assign alu_a        = op_a_r;
    assign alu_b        = op_b_r;
    assign alu_ctrl     = op_ctrl_r;
    assign alu_cin      = op_cin_r;
    assign busy         = (state_r != IDLE);
    assign lock_timeout = pulse_r;

endmodule
